game_ctrl: RTL

Top-level game sequencer for the score datapath. It turns the player's start button into the one-cycle `game_start` / `game_over` pulses and gated 60 Hz `game_tick` strobes that drive the BCD score counter. It also clears that counter between games, handles pause, and keeps a session high score. It sits between the VGA frame timing, the game/collision logic and the score counter.

---
 rtl/game_pkg.sv | 19 +
 rtl/game_ctrl_rise_detect.sv | 22 ++
 rtl/game_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer and its helpers.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RUN       = 2'd2,
        OVER      = 2'd3
    } game_state_t;

    localparam int BCD_W = 16;
    localparam int FRM_W = 8;
    localparam int DIV_W = 4;

    localparam int DEF_COUNTDOWN_FRAMES = 180;
    localparam int DEF_OVER_HOLD_FRAMES = 120;
    localparam int DEF_TICK_DIV         = 1;

endpackage

// File: rtl/game_ctrl_rise_detect.sv
// Rising-edge detector for an already synchronous, debounced button level.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic prev;

    // Previous value resets to 0, so a button held through reset reports one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: start/over pulses, gated score ticks, pause and session high score.
module game_ctrl
    import game_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
    parameter int OVER_HOLD_FRAMES = DEF_OVER_HOLD_FRAMES,
    parameter int TICK_DIV         = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_end,
    input  logic             btn_start,
    input  logic             btn_pause,
    input  logic             collision,
    input  logic [BCD_W-1:0] score_bcd,
    output logic             game_start,
    output logic             game_over,
    output logic             game_tick,
    output logic             score_rst_n,
    output logic [1:0]       state,
    output logic             paused,
    output logic [BCD_W-1:0] high_score,
    output logic             new_high
);

    localparam logic [FRM_W-1:0] CD_LOAD   = FRM_W'(COUNTDOWN_FRAMES);
    localparam logic [FRM_W-1:0] OVER_LOAD = FRM_W'(OVER_HOLD_FRAMES);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);

    game_state_t      state_q;
    logic [FRM_W-1:0] frm_cnt;
    logic [DIV_W-1:0] tick_div;
    logic             start_rise;
    logic             pause_rise;

    rise_detect u_start_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (btn_start),
        .rise  (start_rise)
    );

    rise_detect u_pause_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (btn_pause),
        .rise  (pause_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frm_cnt     <= '0;
            tick_div    <= '0;
            game_start  <= 1'b0;
            game_over   <= 1'b0;
            game_tick   <= 1'b0;
            score_rst_n <= 1'b1;
            paused      <= 1'b0;
            high_score  <= '0;
            new_high    <= 1'b0;
        end else begin
            game_start  <= 1'b0;
            game_over   <= 1'b0;
            game_tick   <= 1'b0;
            score_rst_n <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        state_q     <= COUNTDOWN;
                        frm_cnt     <= CD_LOAD;
                        score_rst_n <= 1'b0;
                    end
                end

                COUNTDOWN: begin
                    if (frame_end) begin
                        if (frm_cnt <= 8'd1) begin
                            state_q    <= RUN;
                            frm_cnt    <= '0;
                            game_start <= 1'b1;
                            new_high   <= 1'b0;
                            tick_div   <= '0;
                            paused     <= 1'b0;
                        end else begin
                            frm_cnt <= frm_cnt - 8'd1;
                        end
                    end
                end

                RUN: begin
                    if (paused) begin
                        if (pause_rise) begin
                            paused <= 1'b0;
                        end
                    end else if (collision) begin
                        // Collision outranks a coincident frame or pause edge.
                        state_q   <= OVER;
                        game_over <= 1'b1;
                        paused    <= 1'b0;
                        frm_cnt   <= OVER_LOAD;
                    end else begin
                        if (pause_rise) begin
                            paused <= 1'b1;
                        end
                        if (frame_end) begin
                            if (tick_div >= DIV_LAST) begin
                                tick_div  <= '0;
                                game_tick <= 1'b1;
                            end else begin
                                tick_div <= tick_div + 4'd1;
                            end
                        end
                    end
                end

                OVER: begin
                    // game_over is high only in the first OVER cycle, when the score is frozen.
                    if (game_over && (score_bcd > high_score)) begin
                        high_score <= score_bcd;
                        new_high   <= 1'b1;
                    end
                    if (frame_end) begin
                        if (frm_cnt <= 8'd1) begin
                            state_q <= IDLE;
                            frm_cnt <= '0;
                        end else begin
                            frm_cnt <= frm_cnt - 8'd1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule
